// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one 512x36 dual-port BRAM, with a 2-entry output skid.
// Define BRAM_FIFO_PARITY_EN to generate per-byte even parity on writes and check it on reads.
module bram_fifo_ctrl #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int AFULL_THRESH = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_perr,
    output logic [ADDR_W+1:0]     count,
    output logic                  almost_full,
    output logic [ADDR_W-1:0]     ram_addra,
    output logic [DATA_W-1:0]     ram_dia,
    output logic [DATA_W/8-1:0]   ram_dipa,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic                  ram_ssra,
    output logic [ADDR_W-1:0]     ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_web,
    output logic                  ram_ssrb,
    input  logic [DATA_W-1:0]     ram_dob,
    input  logic [DATA_W/8-1:0]   ram_dopb
);
    localparam int PAR_W = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int OCC_W = ADDR_W + 2;

    function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAR_W; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec && c != CNT_W'(DEPTH)) return c + CNT_W'(1);
        if (dec && !inc && c != '0) return c - CNT_W'(1);
        return c;
    endfunction

    logic [ADDR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0]  ram_cnt, ram_cnt_next;
    logic              inflight;
    logic [1:0]        obuf_cnt, obuf_next, cap_slot;
    logic [OCC_W-1:0]  count_next;
    logic              push, pop, issue;
    logic              cap_perr_p1;
    logic [DATA_W-1:0] head_data_p2, tail_data_p2;
    logic              head_perr_p2, tail_perr_p2;

    // Stage p0: accept writes and issue reads; ram_cnt excludes this cycle's push so no read/write collision.
    assign push  = rst_n & wr_valid & wr_ready;
    assign pop   = rd_valid & rd_ready;
    assign issue = rst_n & (ram_cnt != '0) & ((obuf_cnt + 2'(inflight) - 2'(pop)) < 2'd2);

    assign obuf_next    = obuf_cnt + 2'(inflight) - 2'(pop);
    assign cap_slot     = obuf_cnt - 2'(pop);
    assign ram_cnt_next = sat_step(ram_cnt, push, issue);
    assign count_next   = OCC_W'(ram_cnt_next) + OCC_W'(issue) + OCC_W'(obuf_next);

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wptr;
    assign ram_dia   = wr_data;
    assign ram_ssra  = 1'b0;
    assign ram_enb   = issue;
    assign ram_addrb = rptr;
    assign ram_web   = 1'b0;
    assign ram_ssrb  = 1'b0;

    assign rd_valid = (obuf_cnt != 2'd0);
    assign rd_data  = head_data_p2;

`ifdef BRAM_FIFO_PARITY_EN
    assign ram_dipa    = byte_parity(wr_data);
    assign cap_perr_p1 = |(byte_parity(ram_dob) ^ ram_dopb);
    assign rd_perr     = rd_valid & head_perr_p2;
`else
    logic unused_par;
    assign ram_dipa    = '0;
    assign cap_perr_p1 = 1'b0;
    assign rd_perr     = 1'b0;
    assign unused_par  = ^{ram_dopb, head_perr_p2};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            ram_cnt     <= '0;
            inflight    <= 1'b0;
            obuf_cnt    <= 2'd0;
            count       <= '0;
            wr_ready    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (push)  wptr <= wptr + ADDR_W'(1);
            if (issue) rptr <= rptr + ADDR_W'(1);
            ram_cnt     <= ram_cnt_next;
            inflight    <= issue;
            obuf_cnt    <= obuf_next;
            count       <= count_next;
            wr_ready    <= (ram_cnt_next < CNT_W'(DEPTH));
            almost_full <= (count_next >= OCC_W'(AFULL_THRESH));
        end
    end

    // Stage p1 -> p2: a pop moves tail to head; a capture lands in the first slot left free after the pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            head_data_p2 <= tail_data_p2;
            head_perr_p2 <= tail_perr_p2;
        end
        if (inflight) begin
            if (cap_slot == 2'd0) begin
                head_data_p2 <= ram_dob;
                head_perr_p2 <= cap_perr_p1;
            end else begin
                tail_data_p2 <= ram_dob;
                tail_perr_p2 <= cap_perr_p1;
            end
        end
    end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Randomized bench for bram_fifo_ctrl: queue-based occupancy/latency model, BRAM model, per-cycle compare.
`timescale 1ns/1ps
module tb_bram_fifo_ctrl;
    localparam int FULL = 514;
`ifdef BRAM_FIFO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, rd_valid, rd_perr, almost_full;
    logic [31:0] rd_data, ram_dia;
    logic [31:0] ram_dob = '0;
    logic [3:0]  ram_dopb = '0;
    logic [10:0] count;
    logic [8:0]  ram_addra, ram_addrb;
    logic [3:0]  ram_dipa;
    logic        ram_ena, ram_wea, ram_ssra, ram_enb, ram_web, ram_ssrb;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.ADDR_W(9), .DATA_W(32), .AFULL_THRESH(480)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_perr(rd_perr),
        .count(count), .almost_full(almost_full),
        .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_dipa(ram_dipa),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_ssra(ram_ssra),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_web(ram_web), .ram_ssrb(ram_ssrb),
        .ram_dob(ram_dob), .ram_dopb(ram_dopb)
    );

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Block RAM model: registered read, one-shot parity-lane corruption on read number flip_seq.
    logic [35:0] mem [512];
    int rd_seq = 0;
    int flip_seq = -1;
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= {ram_dipa, ram_dia};
        if (!rst_n) rd_seq <= 0;
        else if (ram_enb) begin
            ram_dob  <= mem[ram_addrb][31:0];
            ram_dopb <= mem[ram_addrb][35:32] ^ ((rd_seq == flip_seq) ? 4'b0100 : 4'b0000);
            rd_seq   <= rd_seq + 1;
        end
    end

    // Reference model: ordered queue of accepted entries stamped with their push cycle.
    // The head is presented once it is at least 3 cycles old; the FIFO holds at most 514 entries.
    typedef struct {
        logic [31:0] data;
        longint      t;
        int          seq;
    } ent_t;
    ent_t q[$];
    int  nseq = 0;
    bit  m_wrdy = 1'b0;
    bit  armed = 1'b0;
    int  perr_seen = 0;

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].t + 3 <= cyc);
    endfunction

    function automatic logic exp_perr(input int seq);
        return PAR_EN && (seq == flip_seq);
    endfunction

    always @(posedge clk) begin
        bit p, u;
        if (!rst_n) begin
            q.delete();
            nseq   = 0;
            m_wrdy = 1'b0;
            armed  = 1'b1;
        end else begin
            p = m_valid() && rd_ready;
            u = wr_valid && m_wrdy;
            if (p) void'(q.pop_front());
            if (u) begin
                q.push_back('{data: wr_data, t: cyc, seq: nseq});
                nseq++;
            end
            m_wrdy = (q.size() != FULL);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("almost_full", 64'(almost_full), 64'(q.size() >= 480));
            chk("wr_ready", 64'(wr_ready), 64'(m_wrdy));
            chk("rd_valid", 64'(rd_valid), 64'(m_valid()));
            if (m_valid()) begin
                chk("rd_data", 64'(rd_data), 64'(q[0].data));
                chk("rd_perr", 64'(rd_perr), 64'(exp_perr(q[0].seq)));
                if (rd_ready && rd_perr) perr_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input bit rnd);
        int done = 0;
        bit acc;
        for (int k = 0; k < 4000 && done < n; k++) begin
            wr_valid = 1'b1;
            wr_data  = rnd ? $urandom : 32'(done);
            acc      = m_wrdy;
            step();
            if (acc) done++;
        end
        wr_valid = 1'b0;
        chk("push budget", 64'(done), 64'(n));
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int k = 0; k < 2000 && q.size() != 0; k++) step();
        chk("drain budget", 64'(q.size()), 64'd0);
        rd_ready = 1'b0;
    endtask

    initial begin
        int pw [6] = '{90, 50, 95, 20, 70, 100};
        int pr [6] = '{50, 90, 20, 95, 70, 100};

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset count", 64'(count), 64'd0);
        chk("reset wr_ready", 64'(wr_ready), 64'd0);
        chk("reset almost_full", 64'(almost_full), 64'd0);
        chk("reset rd_perr", 64'(rd_perr), 64'd0);
        chk("reset ram enables", 64'({ram_ena, ram_enb, ram_wea}), 64'd0);
        step();
        @(negedge clk);
        chk("wr_ready after reset", 64'(wr_ready), 64'd1);

        // Single word latency
        step();
        wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t1 rd_valid at t+2", 64'(rd_valid), 64'd0);
        step();
        @(negedge clk);
        chk("t1 rd_valid at t+3", 64'(rd_valid), 64'd1);
        chk("t1 rd_data", 64'(rd_data), 64'hA5A5_0001);
        step();
        @(negedge clk);
        chk("t1 count at t+4", 64'(count), 64'd0);

        // Fill to 514 with the consumer stalled, then drain in order
        step();
        rd_ready = 1'b0;
        push_n(514, 1'b0);
        @(negedge clk);
        chk("t2 count full", 64'(count), 64'd514);
        chk("t2 wr_ready full", 64'(wr_ready), 64'd0);
        chk("t2 almost_full", 64'(almost_full), 64'd1);
        chk("t2 head", 64'(rd_data), 64'd0);
        step();
        drain();

        // Streaming: one in, one out per cycle
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            wr_data = $urandom;
            step();
        end
        @(negedge clk);
        chk("t3 steady count", 64'(count), 64'd3);
        step();
        wr_valid = 1'b0;
        drain();

        // Random traffic with varying producer/consumer duty
        for (int ph = 0; ph < 6; ph++) begin
            for (int k = 0; k < 500; k++) begin
                wr_valid = ($urandom_range(99) < pw[ph]);
                rd_ready = ($urandom_range(99) < pr[ph]);
                wr_data  = $urandom;
                step();
            end
        end
        wr_valid = 1'b0;
        drain();

        // Full FIFO: push and pop in the same cycle
        for (int k = 0; k < 2000 && q.size() != FULL; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h5000_0000 | 32'(k);
            step();
        end
        wr_valid = 1'b1; wr_data = 32'hDEAD_0000; rd_ready = 1'b1;
        step();
        rd_ready = 1'b0; wr_data = 32'hDEAD_0001;
        @(negedge clk);
        chk("t4 count after pop", 64'(count), 64'd513);
        chk("t4 wr_ready reopens", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t4 count refilled", 64'(count), 64'd514);
        step();
        drain();

        // Reset with 100 queued and a read in flight
        push_n(100, 1'b1);
        repeat (3) step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5 rd_valid after reset", 64'(rd_valid), 64'd0);
        chk("t5 count after reset", 64'(count), 64'd0);
        step();
        flip_seq = 5;
        wr_valid = 1'b1; wr_data = 32'h1234;
        step();
        wr_valid = 1'b0;
        for (int k = 0; k < 10 && !rd_valid; k++) @(negedge clk);
        chk("t5 rd_valid seen", 64'(rd_valid), 64'd1);
        chk("t5 rd_data", 64'(rd_data), 64'h1234);
        step();

        // Parity lane corruption on the 6th read after reset
        push_n(10, 1'b1);
        drain();
        chk("perr entries", 64'(perr_seen), 64'(PAR_EN));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
